// File: rtl/dflow_gen_sequencer.sv
// dflow_gen_sequencer: run controller that clears, stores, flushes and replays a tuple stream.
module dflow_gen_sequencer #(
    parameter int COUNT_WIDTH   = 32,
    parameter int TIMEOUT_WIDTH = 24,
    parameter int SWRST_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_calib_complete,
    input  logic                     cfg_go,
    input  logic                     cfg_abort,
    input  logic [COUNT_WIDTH-1:0]   cfg_tuple_target,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic                     tuple_acc,
    input  logic                     mem_wr_cmd,
    input  logic                     compelete_replay,
    output logic                     sw_rst,
    output logic                     start_store,
    output logic                     start_replay,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [COUNT_WIDTH-1:0]   stored_count,
    output logic [2:0]               state
);
    typedef enum logic [2:0] {IDLE, CAL, CLEAR, STORE, FLUSH, REPLAY, DONE, ERR} state_t;
    localparam int CW = $clog2(SWRST_CYCLES + 1);
    state_t cur, nxt;
    logic [COUNT_WIDTH-1:0] tgt, acc_cnt, acc_nxt, wr_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo, wd;
    logic [CW-1:0] clr_cnt;
    logic wd_act, wd_hit, calib_lost, idle_like;
    assign state = cur;
    always_comb begin
        idle_like = cur == IDLE || cur == DONE || cur == ERR;
        acc_nxt = (tuple_acc && cur == STORE && acc_cnt != '1) ? acc_cnt + 1'b1 : acc_cnt;
        wr_nxt = (mem_wr_cmd && (cur == STORE || cur == FLUSH) && stored_count != '1) ? stored_count + 1'b1 : stored_count;
        wd_act = (cur == CAL || cur == FLUSH || cur == REPLAY) && tmo != '0;
        // the watchdog fires on the cycle its count would reach the limit
        wd_hit = wd_act && !mem_wr_cmd && ({1'b0, wd} + 1'b1 >= {1'b0, tmo});
        calib_lost = (cur == STORE || cur == FLUSH || cur == REPLAY) && !init_calib_complete;
        nxt = cur;
        case (cur)
            IDLE, DONE, ERR: if (cfg_go) nxt = (cfg_tuple_target == '0) ? ERR : CAL;
            CAL:    if (init_calib_complete) nxt = CLEAR;
            CLEAR:  if (clr_cnt == CW'(SWRST_CYCLES - 1)) nxt = STORE;
            STORE:  if (acc_nxt >= tgt) nxt = FLUSH;
            FLUSH:  if (wr_nxt >= tgt) nxt = REPLAY;
            REPLAY: if (compelete_replay) nxt = DONE;
            default: nxt = cur;
        endcase
        if (wd_hit || calib_lost) nxt = ERR;
        if (cfg_abort) nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= IDLE;
            tgt          <= '0;
            tmo          <= '0;
            acc_cnt      <= '0;
            stored_count <= '0;
            wd           <= '0;
            clr_cnt      <= '0;
            sw_rst       <= 1'b0;
            start_store  <= 1'b0;
            start_replay <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            cur <= nxt;
            if (cfg_go && idle_like && !cfg_abort) begin
                tgt <= cfg_tuple_target;
                tmo <= cfg_timeout;
            end
            acc_cnt      <= (nxt == CLEAR) ? '0 : acc_nxt;
            stored_count <= (nxt == CLEAR) ? '0 : wr_nxt;
            clr_cnt      <= (cur == CLEAR && nxt == CLEAR) ? clr_cnt + 1'b1 : '0;
            wd           <= (nxt != cur || mem_wr_cmd || !wd_act) ? '0 : wd + 1'b1;
            sw_rst       <= nxt == CLEAR;
            start_store  <= nxt == STORE || nxt == FLUSH;
            start_replay <= nxt == REPLAY;
            busy         <= nxt == CAL || nxt == CLEAR || nxt == STORE || nxt == FLUSH || nxt == REPLAY;
            done         <= nxt == DONE;
            error        <= nxt == ERR;
        end
    end
endmodule

// File: tb/tb_dflow_gen_sequencer.sv
// tb_dflow_gen_sequencer: directed scenarios with a queue of expected per-cycle outputs.
module tb_dflow_gen_sequencer;
    logic clk = 0, rst = 1, calib = 1, go = 0, abort = 0, tacc = 0, wcmd = 0, crep = 0;
    logic [31:0] target = 0;
    logic [23:0] timeout = 0;
    logic sw_rst, start_store, start_replay, busy, done, error;
    logic [31:0] stored_count;
    logic [2:0] state;
    int n_chk = 0, n_fail = 0;
    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    dflow_gen_sequencer dut (
        .clk(clk), .rst(rst), .init_calib_complete(calib), .cfg_go(go), .cfg_abort(abort),
        .cfg_tuple_target(target), .cfg_timeout(timeout), .tuple_acc(tacc), .mem_wr_cmd(wcmd),
        .compelete_replay(crep), .sw_rst(sw_rst), .start_store(start_store),
        .start_replay(start_replay), .busy(busy), .done(done), .error(error),
        .stored_count(stored_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // expected outputs for the cycle after this edge are queued, then checked 1ns after it
    task automatic step(input logic [2:0] st, input logic [31:0] cnt);
        exp_t e;
        sb.push_back('{st: st, cnt: cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", {29'd0, state}, {29'd0, e.st});
        chk("sw_rst", {31'd0, sw_rst}, {31'd0, e.st == 3'd2});
        chk("start_store", {31'd0, start_store}, {31'd0, e.st == 3'd3 || e.st == 3'd4});
        chk("start_replay", {31'd0, start_replay}, {31'd0, e.st == 3'd5});
        chk("busy", {31'd0, busy}, {31'd0, e.st >= 3'd1 && e.st <= 3'd5});
        chk("done", {31'd0, done}, {31'd0, e.st == 3'd6});
        chk("error", {31'd0, error}, {31'd0, e.st == 3'd7});
        chk("stored_count", stored_count, e.cnt);
    endtask

    task automatic start_run(input logic [31:0] tgt, input logic [23:0] tmo, input logic [31:0] old_cnt);
        target = tgt;
        timeout = tmo;
        go = 1;
        step(3'd1, old_cnt);
        go = 0;
        for (int i = 0; i < 4; i++) step(3'd2, 0);
        step(3'd3, 0);
    endtask

    initial begin
        // reset
        step(3'd0, 0);
        step(3'd0, 0);
        rst = 0;
        step(3'd0, 0);
        // nominal run
        start_run(3, 0, 0);
        tacc = 1;
        step(3'd3, 0);
        step(3'd3, 0);
        step(3'd4, 0);
        tacc = 0;
        wcmd = 1;
        step(3'd4, 1);
        step(3'd4, 2);
        step(3'd5, 3);
        wcmd = 0;
        for (int i = 0; i < 9; i++) step(3'd5, 3);
        crep = 1;
        step(3'd6, 3);
        crep = 0;
        step(3'd6, 3);
        // zero target from DONE
        target = 0;
        go = 1;
        step(3'd7, 3);
        go = 0;
        step(3'd7, 3);
        // flush timeout after the last write
        start_run(4, 20, 3);
        tacc = 1;
        for (int i = 0; i < 3; i++) step(3'd3, 0);
        step(3'd4, 0);
        tacc = 0;
        wcmd = 1;
        step(3'd4, 1);
        step(3'd4, 2);
        wcmd = 0;
        for (int i = 0; i < 19; i++) step(3'd4, 2);
        step(3'd7, 2);
        step(3'd7, 2);
        // final tuple and write in the same cycle
        start_run(2, 0, 2);
        tacc = 1;
        wcmd = 1;
        step(3'd3, 1);
        step(3'd4, 2);
        tacc = 0;
        wcmd = 0;
        step(3'd5, 2);
        step(3'd5, 2);
        // abort beats go during REPLAY
        target = 5;
        abort = 1;
        go = 1;
        step(3'd0, 2);
        abort = 0;
        go = 0;
        step(3'd0, 2);
        // reset mid-STORE
        start_run(5, 0, 2);
        tacc = 1;
        step(3'd3, 0);
        wcmd = 1;
        step(3'd3, 1);
        tacc = 0;
        wcmd = 0;
        rst = 1;
        step(3'd0, 0);
        rst = 0;
        step(3'd0, 0);
        // calibration loss in REPLAY, then restart
        start_run(1, 0, 0);
        tacc = 1;
        wcmd = 1;
        step(3'd4, 1);
        tacc = 0;
        wcmd = 0;
        step(3'd5, 1);
        step(3'd5, 1);
        calib = 0;
        step(3'd7, 1);
        calib = 1;
        step(3'd7, 1);
        target = 2;
        go = 1;
        step(3'd1, 1);
        go = 0;
        step(3'd2, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dflow_gen_sequencer.md
DFLOW_GEN_SEQUENCER -- requirements
Module: dflow_gen_sequencer

Interface
REQ-001 COUNT_WIDTH, default 32, width of the tuple target and counters.
REQ-002 TIMEOUT_WIDTH, default 24, width of the watchdog limit.
REQ-003 SWRST_CYCLES, default 4, sw_rst pulse length in cycles (>=1).
REQ-004 clk  input  1  single clock, same domain as qdr_clk of the generator core.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 init_calib_complete  input  1  QDR calibration done.
REQ-007 cfg_go  input  1  one-cycle pulse that starts a store+replay run.
REQ-008 cfg_abort  input  1  one-cycle pulse that returns the block to IDLE.
REQ-009 cfg_tuple_target  input  COUNT_WIDTH  number of tuples to store; sampled on cfg_go.
REQ-010 cfg_timeout  input  TIMEOUT_WIDTH  watchdog limit in cycles; 0 disables it; sampled on cfg_go.
REQ-011 tuple_acc  input  1  one tuple accepted at the inqueue (vld & ready).
REQ-012 mem_wr_cmd  input  1  one QDR write command issued.
REQ-013 compelete_replay  input  1  replay finished (level).
REQ-014 sw_rst  output  1  soft reset to the store and replay engines.
REQ-015 start_store  output  1  store enable (level).
REQ-016 start_replay  output  1  replay enable (level).
REQ-017 busy / done / error  output  1 each  status flags.
REQ-018 stored_count  output  COUNT_WIDTH  write commands counted in the current or last run.
REQ-019 state  output  3  encoded FSM state.

Function
REQ-020 The block SHALL implement these states: IDLE=0, CAL=1, CLEAR=2, STORE=3, FLUSH=4, REPLAY=5, DONE=6, ERR=7.
REQ-021 All outputs SHALL be registered; a state transition and its output change SHALL appear one cycle after the triggering input.
REQ-022 In IDLE, DONE or ERR, cfg_go SHALL:
- latch cfg_tuple_target and cfg_timeout;
- go to ERR if the latched target is 0;
- otherwise go to CAL.
REQ-023 In CAL, the FSM SHALL wait for init_calib_complete=1 and then go to CLEAR.
REQ-024 In CLEAR, sw_rst SHALL be 1 for exactly SWRST_CYCLES cycles, the two counters and stored_count SHALL clear, and the FSM SHALL then go to STORE.
REQ-025 In STORE:
- start_store SHALL be 1;
- acc_cnt SHALL increment on tuple_acc and wr_cnt SHALL increment on mem_wr_cmd;
- when both occur in the same cycle, both counters SHALL increment;
- the FSM SHALL go to FLUSH when acc_cnt reaches the target, including the cycle in which the target-th tuple_acc arrives.
REQ-026 In FLUSH:
- start_store SHALL stay 1;
- tuple_acc SHALL no longer count;
- the FSM SHALL go to REPLAY when wr_cnt equals the target.
REQ-027 start_store SHALL drop to 0 in the same cycle REPLAY is entered.
REQ-028 In REPLAY, start_replay SHALL be 1, and the FSM SHALL go to DONE when compelete_replay=1; start_replay SHALL drop on DONE entry.
REQ-029 Both counters SHALL saturate at 2^COUNT_WIDTH-1 and never wrap.
REQ-030 stored_count SHALL equal wr_cnt and SHALL hold its value in DONE and ERR until the next CLEAR.
REQ-031 The watchdog SHALL:
- be active in CAL, FLUSH and REPLAY when cfg_timeout != 0;
- clear on every state entry and on every mem_wr_cmd;
- go to ERR when it reaches the latched cfg_timeout.
REQ-032 busy SHALL be 1 in states CAL through REPLAY; done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-033 cfg_abort in any state SHALL go to IDLE with all enables and flags 0 next cycle; cfg_abort SHALL override cfg_go and any other transition in the same cycle.
REQ-034 cfg_go while busy SHALL be ignored.
REQ-035 A drop of init_calib_complete in STORE, FLUSH or REPLAY SHALL go to ERR.

Reset
REQ-036 With rst=1 at a clock edge, the next state SHALL be IDLE and sw_rst, start_store, start_replay, busy, done, error, stored_count, the counters and the watchdog SHALL all be 0; this applies mid-run as well.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Nominal: target=3, timeout=0, calib=1, 3 tuple_acc then 3 mem_wr_cmd, compelete_replay after 10 cycles -> states 1,2 (sw_rst high 4 cycles),3,4,5,6; done=1; stored_count=3.
- Zero target: cfg_go with target=0 -> ERR, error=1, no sw_rst.
- Flush timeout: target=4, timeout=20, only 2 mem_wr_cmd -> ERR 20 cycles after the last write; start_store=0; stored_count=2.
- Same-cycle events: tuple_acc and mem_wr_cmd together on the final tuple -> both counters reach the target, FLUSH is passed through straight to REPLAY on the next cycle.
- Abort/reset priority: cfg_abort and cfg_go in the same cycle during REPLAY -> IDLE, start_replay=0; rst during STORE -> all outputs 0 next cycle.
- Calibration loss: calib deasserted during REPLAY -> ERR; a subsequent cfg_go with calib=1 -> CAL, then CLEAR with stored_count cleared.
